// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
// Shared definitions for the Sudoku elapsed-game timer / display scanner:
//   - state_e   : game timer FSM states
//   - SEG_OFF   : all segments dark (active-low, {g,f,e,d,c,b,a})
//   - SEG_LUT   : BCD 0..9 to active-low seven-segment patterns
//   - seg_decode: BCD digit to pattern, anything above 9 is dark
// -----------------------------------------------------------------------------
package sudoku_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] r;
        r = SEG_OFF;
        if (d <= 4'd9) begin
            r = SEG_LUT[d];
        end
        return r;
    endfunction

endpackage

// File: rtl/sudoku_bcd_digit.sv
// -----------------------------------------------------------------------------
// sudoku_bcd_digit
// One mod-N BCD counter digit.
//   clk   : master clock
//   clr_n : asynchronous reset, active-low (value -> 0)
//   clr   : synchronous clear to 0, wins over inc
//   inc   : advance by one; wraps N-1 -> 0
//   val   : current digit value
//   carry : combinational, high when inc is asserted on the last value
// -----------------------------------------------------------------------------
module sudoku_bcd_digit #(
    parameter int unsigned N = 10
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] val,
    output logic       carry
);

    localparam logic [3:0] LAST = 4'(N - 1);

    logic [3:0] val_q;
    logic [3:0] val_d;

    assign carry = inc && (val_q == LAST);
    assign val   = val_q;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = 4'd0;
        end else if (inc) begin
            val_d = carry ? 4'd0 : val_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            val_q <= 4'd0;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/sudoku_timer_disp.sv
// -----------------------------------------------------------------------------
// sudoku_timer_disp
// Elapsed-game MM:SS timer with a 4-digit multiplexed common-anode display.
//   clk      : master clock
//   clr_n    : asynchronous reset, active-low
//   sec_lvl  : 1 Hz square wave, one second per rising edge
//   scan_lvl : scan square wave, one digit step per rising edge
//   start    : pulse, clear the count and run (highest priority)
//   pause    : level, freeze the count while high
//   solved   : pulse, freeze the count for good (until next start)
//   an       : digit anodes, active-low, an[0] = rightmost (seconds units)
//   seg      : segments {g,f,e,d,c,b,a}, active-low
//   dp       : colon after the minutes, active-low, only on digit 1
//   running  : registered, state is RUN
//   done     : registered, state is DONE
// Parameter MAX_MIN (1..99): the count saturates at MAX_MIN:59.
// Build option SUDOKU_LEAD_BLANK_EN: blank the tens-of-minutes digit when 0.
// -----------------------------------------------------------------------------
module sudoku_timer_disp
    import sudoku_pkg::*;
#(
    parameter int unsigned MAX_MIN = 99
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       sec_lvl,
    input  logic       scan_lvl,
    input  logic       start,
    input  logic       pause,
    input  logic       solved,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       running,
    output logic       done
);

    localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

    state_e     state_q, state_d;
    logic       sec_q, scan_q;
    logic [1:0] idx_q, idx_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       running_q, running_d;
    logic       done_q, done_d;

    logic       sec_pulse, scan_pulse, at_max, tick;
    logic [3:0] digit_val [0:3];
    logic [3:0] inc_vec, carry_vec;
    logic       carry_unused;
    logic [3:0] digit_sel;

    assign sec_pulse  = sec_lvl & ~sec_q;
    assign scan_pulse = scan_lvl & ~scan_q;

    assign at_max = (digit_val[3] == MAX_M1) && (digit_val[2] == MAX_M0) &&
                    (digit_val[1] == 4'd5)   && (digit_val[0] == 4'd9);

    // A second only counts in RUN when nothing else claims the cycle;
    // the tick at MAX_MIN:59 moves to DONE instead of wrapping.
    assign tick = (state_q == ST_RUN) && sec_pulse && !start && !solved &&
                  !pause && !at_max;

    // Digits {m1,m0,s1,s0} = digit_val[3:0]; carry ripples upward.
    assign inc_vec      = {carry_vec[2:0], tick};
    assign carry_unused = carry_vec[3];

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        sudoku_bcd_digit #(
            .N ((gi == 1) ? 6 : 10)
        ) u_digit (
            .clk   (clk),
            .clr_n (clr_n),
            .clr   (start),
            .inc   (inc_vec[gi]),
            .val   (digit_val[gi]),
            .carry (carry_vec[gi])
        );
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (solved) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (sec_pulse && at_max) begin
                        state_d = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (solved) begin
                        state_d = ST_DONE;
                    end else if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Display registers are built from the current idx, so a new index
    // shows up one edge after the scan pulse that selected it.
    always_comb begin
        idx_d     = idx_q + {1'b0, scan_pulse};
        digit_sel = digit_val[idx_q];
        an_d      = ~(4'b0001 << idx_q);
        seg_d     = seg_decode(digit_sel);
`ifdef SUDOKU_LEAD_BLANK_EN
        if ((idx_q == 2'd3) && (digit_val[3] == 4'd0)) begin
            seg_d = SEG_OFF;
        end
`endif
        dp_d = 1'b1;
        if (idx_q == 2'd1) begin
            case (state_q)
                ST_RUN:   dp_d = sec_q;
                ST_PAUSE: dp_d = 1'b0;
                ST_DONE:  dp_d = 1'b0;
                default:  dp_d = 1'b1;
            endcase
        end
        running_d = (state_q == ST_RUN);
        done_d    = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            sec_q     <= 1'b0;
            scan_q    <= 1'b0;
            idx_q     <= 2'd0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_lvl;
            scan_q    <= scan_lvl;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sudoku_timer_disp.sv
// -----------------------------------------------------------------------------
// tb_sudoku_timer_disp
// Self-checking bench for sudoku_timer_disp. A reference model keeps the
// elapsed time as a plain number of seconds plus a game mode, and predicts
// every registered output each cycle. Honours SUDOKU_LEAD_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_sudoku_timer_disp;

    localparam int MAX_MIN = 99;
    localparam int MAXS    = MAX_MIN * 60 + 59;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       clr_n, sec_lvl, scan_lvl, start, pause, solved;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, running, done;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_mode, m_secs, m_idx;
    bit m_sec_prev, m_scan_prev;

    // predicted outputs
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_run, e_done;

    always #5 clk = ~clk;

    sudoku_timer_disp #(
        .MAX_MIN (MAX_MIN)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .sec_lvl  (sec_lvl),
        .scan_lvl (scan_lvl),
        .start    (start),
        .pause    (pause),
        .solved   (solved),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .running  (running),
        .done     (done)
    );

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // digit k of MM:SS, k=0 seconds units .. k=3 tens of minutes
    function automatic int digit_of(input int secs, input int k);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        case (k)
            0: return ss % 10;
            1: return ss / 10;
            2: return mm % 10;
            default: return mm / 10;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".an"},      {3'b0, an},      {3'b0, e_an});
        chk({tag, ".seg"},     seg,             e_seg);
        chk({tag, ".dp"},      {6'b0, dp},      {6'b0, e_dp});
        chk({tag, ".running"}, {6'b0, running}, {6'b0, e_run});
        chk({tag, ".done"},    {6'b0, done},    {6'b0, e_done});
    endtask

    // One clock edge: outputs registered at this edge come from the state
    // before it; then the model absorbs the inputs sampled at this edge.
    task automatic step();
        bit sp, cp;
        e_an = 4'hF;
        e_an[m_idx] = 1'b0;
        e_seg = ref_seg(digit_of(m_secs, m_idx));
`ifdef SUDOKU_LEAD_BLANK_EN
        if (m_idx == 3 && (m_secs / 600) == 0) e_seg = 7'h7F;
`endif
        e_dp = 1'b1;
        if (m_idx == 1) begin
            if (m_mode == M_RUN)       e_dp = m_sec_prev;
            else if (m_mode != M_IDLE) e_dp = 1'b0;
        end
        e_run  = (m_mode == M_RUN);
        e_done = (m_mode == M_DONE);

        sp = sec_lvl && !m_sec_prev;
        cp = scan_lvl && !m_scan_prev;
        if (start) begin
            m_mode = M_RUN;
            m_secs = 0;
        end else if (m_mode == M_RUN) begin
            if (solved)      m_mode = M_DONE;
            else if (pause)  m_mode = M_PAUSE;
            else if (sp) begin
                if (m_secs == MAXS) m_mode = M_DONE;
                else                m_secs++;
            end
        end else if (m_mode == M_PAUSE) begin
            if (solved)      m_mode = M_DONE;
            else if (!pause) m_mode = M_RUN;
        end
        if (cp) m_idx = (m_idx + 1) % 4;
        m_sec_prev  = sec_lvl;
        m_scan_prev = scan_lvl;

        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            sec_lvl = 1'b1;
            repeat ($urandom_range(1, 2)) step();
            sec_lvl = 1'b0;
            repeat ($urandom_range(1, 2)) step();
        end
    endtask

    // walk all four digits, checking the display at each
    task automatic show(input string tag);
        for (int k = 0; k < 4; k++) begin
            scan_lvl = 1'b1;
            step();
            scan_lvl = 1'b0;
            step();
            check_outs(tag);
        end
        $display("show %s: model %02d:%02d mode=%0d", tag, m_secs / 60, m_secs % 60, m_mode);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_outs(tag);
    endtask

    initial begin
        clr_n = 1'b0; sec_lvl = 1'b0; scan_lvl = 1'b0;
        start = 1'b0; pause = 1'b0; solved = 1'b0;
        m_mode = M_IDLE; m_secs = 0; m_idx = 0;
        m_sec_prev = 1'b0; m_scan_prev = 1'b0;

        // reset values while clr_n is held low
        repeat (3) @(posedge clk);
        #1;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_run = 1'b0; e_done = 1'b0;
        check_outs("reset");
        clr_n = 1'b1;

        // IDLE: colon dark, pause/solved ignored
        show("idle");
        pause = 1'b1; step();
        solved = 1'b1; step();
        solved = 1'b0; step();
        pause = 1'b0; step();
        check_outs("idle_ignore");

        // 61 seconds -> 01:01
        do_start("start1");
        tick(61);
        show("t61");

        // 5 seconds paused, then 3 counted
        pause = 1'b1; step();
        tick(5);
        show("paused");
        pause = 1'b0; step();
        tick(3);
        show("resumed");

        // colon follows the seconds square wave in RUN
        while (m_idx != 0) begin
            scan_lvl = 1'b1; step();
            scan_lvl = 1'b0; step();
        end
        sec_lvl = 1'b1; scan_lvl = 1'b1; step();
        scan_lvl = 1'b0; step();
        check_outs("colon_hi");
        sec_lvl = 1'b0; step(); step();
        check_outs("colon_lo");

        // restart mid-count, then a random run length
        do_start("restart");
        tick($urandom_range(20, 80));
        show("rand_run");

        // solved together with a second edge at 00:10
        do_start("start2");
        tick(10);
        sec_lvl = 1'b1; solved = 1'b1; step();
        sec_lvl = 1'b0; solved = 1'b0; step();
        check_outs("solved");
        tick(4);
        show("solved_hold");
        do_start("after_solved");
        show("cleared");

        // saturation at MAX_MIN:59
        tick(MAXS - 1);
        show("at_9958");
        tick(3);
        show("sat");
        tick(2);
        show("sat_hold");

        // leading digit at 05:00
        do_start("start3");
        tick(300);
        show("lead");

        // random traffic, checked every cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)   sec_lvl  = ~sec_lvl;
            if ($urandom_range(0, 2) == 0)   scan_lvl = ~scan_lvl;
            if ($urandom_range(0, 60) == 0)  pause    = ~pause;
            start  = ($urandom_range(0, 499) == 0);
            solved = ($urandom_range(0, 399) == 0);
            step();
            check_outs("rand");
        end
        start = 1'b0; solved = 1'b0; pause = 1'b0;
        step();
        check_outs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
